// File: rtl/led_pwm_pkg.sv
// Shared types and register layout for the multi-channel LED PWM driver.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_DUTY   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // STATUS holds the counter from bit 0 and the led state directly above it (bit CW).
    localparam int STATUS_CNT_LSB = 0;

    function automatic logic is_counting(mode_e m);
        return (m == MODE_PWM) || (m == MODE_BLINK);
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active period and duty, tick counter, blink flop and registered led.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          wr_ctrl,
    input  logic          wr_period,
    input  logic          wr_duty,
    input  logic [CW-1:0] wdata,
    input  logic [1:0]    rd_sel,
    output logic          led,
    output logic [CW:0]   status,
    output logic [31:0]   rdata
);

    mode_e         mode_q, mode_d;
    logic [CW-1:0] sh_period_q, sh_period_d;
    logic [CW-1:0] sh_duty_q, sh_duty_d;
    logic [CW-1:0] act_period_q, act_period_d;
    logic [CW-1:0] act_duty_q, act_duty_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;
    logic          led_q, led_d;
    logic          wrap;

    always_comb begin
        mode_d       = mode_q;
        sh_period_d  = sh_period_q;
        sh_duty_d    = sh_duty_q;
        act_period_d = act_period_q;
        act_duty_d   = act_duty_q;
        cnt_d        = cnt_q;
        blink_d      = blink_q;

        wrap = tick && is_counting(mode_q) && (act_period_q != '0)
               && (cnt_q == act_period_q - CW'(1));

        if (wr_period) sh_period_d = wdata;
        if (wr_duty)   sh_duty_d   = wdata;

        // A CTRL write overrides any wrap landing in the same cycle.
        if (wr_ctrl) begin
            mode_d       = mode_e'(wdata[1:0]);
            cnt_d        = '0;
            blink_d      = 1'b0;
            act_period_d = sh_period_q;
            act_duty_d   = sh_duty_q;
        end else if (!is_counting(mode_q)) begin
            act_period_d = sh_period_d;
            act_duty_d   = sh_duty_d;
        end else if (wrap) begin
            // Old shadow is used so a write arriving on this tick waits for the next wrap.
            cnt_d        = '0;
            act_period_d = sh_period_q;
            act_duty_d   = sh_duty_q;
            if (mode_q == MODE_BLINK) blink_d = ~blink_q;
        end else if (tick && (act_period_q != '0)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        case (mode_q)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_PWM:   led_d = (act_period_q != '0) && (cnt_q < act_duty_q);
            MODE_BLINK: led_d = blink_q;
            default:    led_d = 1'b0;
        endcase
    end

    always_comb begin
        case (rd_sel)
            REG_CTRL:   rdata = {30'b0, mode_q};
            REG_PERIOD: rdata = {{(32-CW){1'b0}}, sh_period_q};
            REG_DUTY:   rdata = {{(32-CW){1'b0}}, sh_duty_q};
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= MODE_OFF;
            sh_period_q  <= '0;
            sh_duty_q    <= '0;
            act_period_q <= '0;
            act_duty_q   <= '0;
            cnt_q        <= '0;
            blink_q      <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            sh_period_q  <= sh_period_d;
            sh_duty_q    <= sh_duty_d;
            act_period_q <= act_period_d;
            act_duty_q   <= act_duty_d;
            cnt_q        <= cnt_d;
            blink_q      <= blink_d;
            led_q        <= led_d;
        end
    end

    assign led    = led_q;
    assign status = {led_q, cnt_q};

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver top: shared prescaler, single-outstanding register bus, channel array.
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CW    = 16,
    parameter int PRESC = 50,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW   = 2 + CHW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [AW-1:0]  req_addr,
    input  logic [31:0]    req_wdata,
    output logic           rsp_valid,
    output logic [31:0]    rsp_rdata,
    output logic [NCH-1:0] led
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0]  presc_q, presc_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;
    logic           tick, accept, ch_ok, wr_en;
    logic [CHW-1:0] ch_idx;
    logic [1:0]     reg_idx;
    logic [31:0]    rd_mux;
    logic [31:0]    rdata_ch [NCH];
    logic [CW:0]    status_ch [NCH];
    logic           unused_wdata_hi;

    assign unused_wdata_hi = ^req_wdata[31:CW];

    assign tick      = (presc_q == PW'(PRESC - 1));
    assign req_ready = !rsp_valid_q;
    assign accept    = req_valid && req_ready;
    assign ch_idx    = req_addr[AW-1:2];
    assign reg_idx   = req_addr[1:0];
    assign ch_ok     = (int'(ch_idx) < NCH);
    assign wr_en     = accept && req_we && ch_ok;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        led_pwm_channel #(.CW(CW)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .wr_ctrl   (wr_en && (ch_idx == CHW'(i)) && (reg_idx == REG_CTRL)),
            .wr_period (wr_en && (ch_idx == CHW'(i)) && (reg_idx == REG_PERIOD)),
            .wr_duty   (wr_en && (ch_idx == CHW'(i)) && (reg_idx == REG_DUTY)),
            .wdata     (req_wdata[CW-1:0]),
            .rd_sel    (reg_idx),
            .led       (led[i]),
            .status    (status_ch[i]),
            .rdata     (rdata_ch[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(ch_idx) == i) begin
                rd_mux = (reg_idx == REG_STATUS) ? {{(31-CW){1'b0}}, status_ch[i]} : rdata_ch[i];
            end
        end
        rsp_valid_d = accept;
        rsp_rdata_d = (accept && !req_we && ch_ok) ? rd_mux : '0;
        presc_d     = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            presc_q     <= presc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Randomised and directed bench for led_pwm_ctrl against a cycle-level behavioural model.
module tb_led_pwm_ctrl;

    localparam int NCH   = 3;
    localparam int CW    = 8;
    localparam int PRESC = 2;
    localparam int AW    = 4;
    localparam int MASK  = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_we = 1'b0;
    logic [AW-1:0]  req_addr = '0;
    logic [31:0]    req_wdata = '0;
    logic           rsp_valid;
    logic [31:0]    rsp_rdata;
    logic [NCH-1:0] led;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int          m_presc;
    int          m_mode [NCH];
    int          m_shp [NCH];
    int          m_shd [NCH];
    int          m_ap [NCH];
    int          m_ad [NCH];
    int          m_cnt [NCH];
    bit          m_blink [NCH];
    bit          m_led [NCH];
    bit          m_rsp;
    logic [31:0] m_rdata;

    led_pwm_ctrl #(.NCH(NCH), .CW(CW), .PRESC(PRESC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_rsp   = 0;
        m_rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = 0; m_shp[i] = 0; m_shd[i] = 0; m_ap[i] = 0; m_ad[i] = 0;
            m_cnt[i] = 0; m_blink[i] = 0; m_led[i] = 0;
        end
    endtask

    function automatic bit led_rule(int i);
        case (m_mode[i])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (m_ap[i] > 0) && (m_cnt[i] < m_ad[i]);
            default: return m_blink[i];
        endcase
    endfunction

    function automatic logic [31:0] reg_value(int i, int rg);
        case (rg)
            0:       return 32'(m_mode[i]);
            1:       return 32'(m_shp[i]);
            2:       return 32'(m_shd[i]);
            default: return 32'((int'(m_led[i]) << CW) | m_cnt[i]);
        endcase
    endfunction

    // Advances the model across one rising edge using the inputs held during the cycle.
    task automatic model_step();
        bit          tick, acc, wc, wp, wd;
        int          ch, rg, old_shp, old_shd, data;
        logic [31:0] rd;
        if (rst) begin
            model_reset();
            return;
        end
        tick = (m_presc == PRESC - 1);
        acc  = req_valid && !m_rsp;
        ch   = int'(req_addr) >> 2;
        rg   = int'(req_addr) & 3;
        data = int'(req_wdata & 32'(MASK));
        rd   = '0;
        if (acc && !req_we && ch < NCH) rd = reg_value(ch, rg);
        for (int i = 0; i < NCH; i++) m_led[i] = led_rule(i);
        for (int i = 0; i < NCH; i++) begin
            wc = acc && req_we && ch == i && rg == 0;
            wp = acc && req_we && ch == i && rg == 1;
            wd = acc && req_we && ch == i && rg == 2;
            old_shp = m_shp[i];
            old_shd = m_shd[i];
            if (wp) m_shp[i] = data;
            if (wd) m_shd[i] = data;
            if (wc) begin
                m_mode[i] = int'(req_wdata[1:0]);
                m_cnt[i] = 0; m_blink[i] = 0;
                m_ap[i] = old_shp; m_ad[i] = old_shd;
            end else if (m_mode[i] < 2) begin
                m_ap[i] = m_shp[i]; m_ad[i] = m_shd[i];
            end else if (tick && m_ap[i] > 0) begin
                if (m_cnt[i] == m_ap[i] - 1) begin
                    m_cnt[i] = 0;
                    m_ap[i] = old_shp; m_ad[i] = old_shd;
                    if (m_mode[i] == 3) m_blink[i] = !m_blink[i];
                end else begin
                    m_cnt[i]++;
                end
            end
        end
        m_presc = tick ? 0 : m_presc + 1;
        m_rsp   = acc;
        m_rdata = rd;
    endtask

    task automatic cycle();
        logic [NCH-1:0] e;
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < NCH; i++) e[i] = m_led[i];
        check("led", 32'(led), 32'(e));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        check("req_ready", 32'(req_ready), 32'(!m_rsp));
        check("rsp_rdata", rsp_rdata, m_rdata);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic bus(input bit we, input int ch, input int rg, input logic [31:0] data,
                       output logic [31:0] rd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = AW'((ch << 2) | rg);
        req_wdata = data;
        cycle();
        check("rsp_pulse", 32'(rsp_valid), 32'd1);
        check("ready_low_in_rsp", 32'(req_ready), 32'd0);
        rd = rsp_rdata;
        req_valid = 1'b0;
        req_we    = 1'b0;
        cycle();
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    task automatic count_ones(input int ch, input int n, output int ones);
        ones = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            ones += int'(led[ch]);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          ones;
        int          rg;

        model_reset();
        idle(3);
        check("reset_led", 32'(led), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        idle(2);

        // Bus write/read
        bus(1, 1, 1, 32'd10, rd);
        bus(0, 1, 1, 32'd0, rd);
        check("rd_period_ch1", rd, 32'd10);

        // Out-of-range channel
        bus(1, 3, 1, 32'd7, rd);
        check("bad_wr_rdata", rd, 32'd0);
        bus(0, 3, 1, 32'd0, rd);
        check("bad_rd_period", rd, 32'd0);
        bus(0, 3, 0, 32'd0, rd);
        check("bad_rd_ctrl", rd, 32'd0);
        bus(0, 1, 1, 32'd0, rd);
        check("ch1_untouched", rd, 32'd10);

        // PWM on ch0: period 4, 8 clk per PWM cycle at PRESC=2
        bus(1, 0, 1, 32'd4, rd);
        bus(1, 0, 2, 32'd1, rd);
        bus(1, 0, 0, 32'd2, rd);
        idle(20);
        count_ones(0, 64, ones);
        check("pwm_duty1", 32'(ones), 32'd16);
        bus(1, 0, 2, 32'd0, rd);
        idle(20);
        count_ones(0, 64, ones);
        check("pwm_duty0", 32'(ones), 32'd0);
        bus(1, 0, 2, 32'd4, rd);
        idle(20);
        count_ones(0, 64, ones);
        check("pwm_duty_full", 32'(ones), 32'd64);

        // Shadowed period change mid-cycle
        bus(1, 0, 1, 32'd8, rd);
        bus(1, 0, 2, 32'd2, rd);
        bus(1, 0, 0, 32'd2, rd);
        idle(5);
        bus(1, 0, 1, 32'd3, rd);
        idle(30);
        count_ones(0, 60, ones);
        check("shadow_steady", 32'(ones), 32'd40);

        // BLINK on ch1: period 3 -> toggle every 6 clk
        bus(1, 1, 1, 32'd3, rd);
        bus(1, 1, 0, 32'd3, rd);
        idle(12);
        count_ones(1, 48, ones);
        check("blink_duty", 32'(ones), 32'd24);
        idle(7);
        bus(1, 1, 0, 32'd3, rd);
        check("blink_restart", 32'(led[1]), 32'd0);
        bus(1, 1, 1, 32'd0, rd);
        bus(1, 1, 0, 32'd3, rd);
        idle(4);
        count_ones(1, 48, ones);
        check("blink_period0", 32'(ones), 32'd0);

        // Largest legal period with duty >= period
        bus(1, 2, 1, 32'(MASK), rd);
        bus(1, 2, 2, 32'(MASK), rd);
        bus(1, 2, 0, 32'd2, rd);
        idle(4);
        count_ones(2, 100, ones);
        check("pwm_max_period", 32'(ones), 32'd100);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            req_valid = ($urandom_range(0, 2) == 0);
            req_we    = ($urandom_range(0, 3) != 0);
            req_addr  = AW'($urandom_range(0, 15));
            rg        = int'(req_addr[1:0]);
            if (rg == 0) begin
                if ($urandom_range(0, 3) != 0) req_valid = 1'b0;
                req_wdata = $urandom_range(0, 3) | ($urandom_range(0, 1) ? 32'hABCD_0000 : 32'h0);
            end else if ($urandom_range(0, 9) == 0) begin
                req_wdata = $urandom();
            end else begin
                req_wdata = $urandom_range(0, 9);
            end
            cycle();
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        idle(2);

        // Async reset with an in-flight response
        req_valid = 1'b1;
        req_addr  = AW'(4'd1);
        cycle();
        req_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("rst_led", 32'(led), 32'd0);
        check("rst_rsp_dropped", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        cycle();
        rst = 1'b0;
        idle(2);
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 4; r++) begin
                bus(0, c, r, 32'd0, rd);
                check("rst_readback", rd, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
